// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Pin polarity, FSM states and bus-owner encoding.
package dmem_pkg;

  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 32;

  localparam logic MEM_ON  = 1'b0;
  localparam logic MEM_OFF = 1'b1;

  typedef enum logic {
    IDLE,
    CPU_RD_WAIT
  } st_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_DMA
  } owner_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Core, DMA and SRAM pin bundle around the arbiter.
// master = requesters + memory, slave = arbiter.
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  logic              CEN;
  logic              WEN;
  logic              OEN;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] Data2Mem;
  logic [DATA_W-1:0] ReadDataMem;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  CEN, WEN, OEN, A, Data2Mem,
    output ReadDataMem
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output CEN, WEN, OEN, A, Data2Mem,
    input  ReadDataMem
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter, bit 0 = CPU, bit 1 = DMA.
// rr_q = 0 favours requester 0; it flips toward the loser after any grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic rr_q;
  logic rr_d;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = rr_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt[0]) begin
      rr_d = 1'b1;
    end else if (gnt[1]) begin
      rr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data SRAM between core load/store and DMA.
// Hides the one-cycle read latency from the core with a stall.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  st_e               st_q;
  st_e               st_d;
  logic              dma_rd_pend_q;
  logic              dma_rd_pend_d;

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              cpu_gnt;
  logic              dma_gnt;
  owner_e            owner;

  logic              cen;
  logic              wen;
  logic              oen;
  logic [ADDR_W-1:0] a_mux;
  logic [DATA_W-1:0] d_mux;

  // Requests are masked in reset so the pins stay idle asynchronously.
  assign req[0] = rst_n & bus.cpu_req & (st_q == IDLE);
  assign req[1] = rst_n & bus.dma_req;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  assign cpu_gnt = gnt[0];
  assign dma_gnt = gnt[1];

  always_comb begin
    owner = OWN_NONE;
    unique case (1'b1)
      cpu_gnt: owner = OWN_CPU;
      dma_gnt: owner = OWN_DMA;
      default: owner = OWN_NONE;
    endcase
  end

  always_comb begin
    cen   = MEM_OFF;
    wen   = MEM_OFF;
    oen   = MEM_OFF;
    a_mux = '0;
    d_mux = '0;
    unique case (owner)
      OWN_CPU: begin
        cen   = MEM_ON;
        wen   = bus.cpu_we ? MEM_ON : MEM_OFF;
        oen   = bus.cpu_we ? MEM_OFF : MEM_ON;
        a_mux = bus.cpu_addr;
        d_mux = bus.cpu_wdata;
      end
      OWN_DMA: begin
        cen   = MEM_ON;
        wen   = bus.dma_we ? MEM_ON : MEM_OFF;
        oen   = bus.dma_we ? MEM_OFF : MEM_ON;
        a_mux = bus.dma_addr;
        d_mux = bus.dma_wdata;
      end
      default: begin
        cen = MEM_OFF;
      end
    endcase
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE: begin
        if (cpu_gnt && !bus.cpu_we) begin
          st_d = CPU_RD_WAIT;
        end
      end
      CPU_RD_WAIT: st_d = IDLE;
      default:     st_d = IDLE;
    endcase
    dma_rd_pend_d = dma_gnt & ~bus.dma_we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q          <= IDLE;
      dma_rd_pend_q <= 1'b0;
    end else begin
      st_q          <= st_d;
      dma_rd_pend_q <= dma_rd_pend_d;
    end
  end

  assign bus.CEN      = cen;
  assign bus.WEN      = wen;
  assign bus.OEN      = oen;
  assign bus.A        = a_mux;
  assign bus.Data2Mem = d_mux;

  // Loads stall in the issue cycle; stores only while losing.
  assign bus.cpu_stall = rst_n & bus.cpu_req & (st_q == IDLE)
                       & (~cpu_gnt | ~bus.cpu_we);

  assign bus.cpu_rdata  = (st_q == CPU_RD_WAIT) ? bus.ReadDataMem : '0;
  assign bus.dma_gnt    = dma_gnt;
  assign bus.dma_rvalid = dma_rd_pend_q;
  assign bus.dma_rdata  = dma_rd_pend_q ? bus.ReadDataMem : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 128-word SRAM.
// Outputs are sampled on the falling edge; inputs change 1ns after rising.
module tb_dmem_arbiter;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_tot;

  dmem_arbiter_if #(.ADDR_W(7), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(7), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [128];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!bus.CEN) begin
      if (!bus.WEN) begin
        mem[bus.A] <= bus.Data2Mem;
      end else if (!bus.OEN) begin
        bus.ReadDataMem <= mem[bus.A];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.dma_req   = 1'b0;
    bus.dma_we    = 1'b0;
    bus.dma_addr  = '0;
    bus.dma_wdata = '0;
  endtask

  initial begin
    n_pass = 0;
    n_tot  = 0;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[7'h10] = 32'hA5A5_0010;
    bus.ReadDataMem = '0;
    rst_n = 1'b0;
    idle_in();

    // Traffic present while in reset: pins must stay idle
    bus.cpu_req   = 1'b1;
    bus.cpu_addr  = 7'h10;
    bus.dma_req   = 1'b1;
    bus.dma_we    = 1'b1;
    bus.dma_addr  = 7'h20;
    bus.dma_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("rst_cen", bus.CEN, 1);
    chk("rst_wen", bus.WEN, 1);
    chk("rst_oen", bus.OEN, 1);
    chk("rst_a", bus.A, 0);
    chk("rst_d2m", bus.Data2Mem, 0);
    chk("rst_stall", bus.cpu_stall, 0);
    chk("rst_gnt", bus.dma_gnt, 0);
    chk("rst_rvalid", bus.dma_rvalid, 0);
    chk("rst_rdata", bus.cpu_rdata, 0);

    // Contention after reset: CPU load wins
    next_cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("ct_cen", bus.CEN, 0);
    chk("ct_oen", bus.OEN, 0);
    chk("ct_wen", bus.WEN, 1);
    chk("ct_a", bus.A, 32'h10);
    chk("ct_stall", bus.cpu_stall, 1);
    chk("ct_dgnt", bus.dma_gnt, 0);

    // Load return overlaps the DMA write issue
    next_cyc();
    @(negedge clk);
    chk("ct2_rdata", bus.cpu_rdata, 32'hA5A5_0010);
    chk("ct2_stall", bus.cpu_stall, 0);
    chk("ct2_dgnt", bus.dma_gnt, 1);
    chk("ct2_a", bus.A, 32'h20);
    chk("ct2_wen", bus.WEN, 0);
    chk("ct2_d2m", bus.Data2Mem, 32'h1234_5678);

    // Lone CPU store, zero stall
    next_cyc();
    idle_in();
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 7'h05;
    bus.cpu_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("st_cen", bus.CEN, 0);
    chk("st_wen", bus.WEN, 0);
    chk("st_a", bus.A, 32'h05);
    chk("st_d2m", bus.Data2Mem, 32'hDEAD_BEEF);
    chk("st_stall", bus.cpu_stall, 0);

    // Store vs DMA read after a CPU grant: DMA wins
    next_cyc();
    bus.cpu_addr  = 7'h06;
    bus.cpu_wdata = 32'h0000_0066;
    bus.dma_req   = 1'b1;
    bus.dma_we    = 1'b0;
    bus.dma_addr  = 7'h20;
    @(negedge clk);
    chk("c2_dgnt", bus.dma_gnt, 1);
    chk("c2_stall", bus.cpu_stall, 1);
    chk("c2_a", bus.A, 32'h20);
    chk("c2_oen", bus.OEN, 0);

    next_cyc();
    bus.dma_req = 1'b0;
    @(negedge clk);
    chk("c3_stall", bus.cpu_stall, 0);
    chk("c3_a", bus.A, 32'h06);
    chk("c3_wen", bus.WEN, 0);
    chk("c3_rvalid", bus.dma_rvalid, 1);
    chk("c3_rdata", bus.dma_rdata, 32'h1234_5678);

    // Uncontended load of the stored word
    next_cyc();
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 7'h05;
    @(negedge clk);
    chk("ld_stall", bus.cpu_stall, 1);
    chk("ld_oen", bus.OEN, 0);
    chk("ld_a", bus.A, 32'h05);

    next_cyc();
    @(negedge clk);
    chk("ld2_stall", bus.cpu_stall, 0);
    chk("ld2_rdata", bus.cpu_rdata, 32'hDEAD_BEEF);
    chk("ld2_cen", bus.CEN, 1);

    // DMA burst read, CPU idle
    next_cyc();
    idle_in();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) next_cyc();
      bus.dma_req  = 1'b1;
      bus.dma_addr = 7'(k);
      @(negedge clk);
      chk($sformatf("bu_gnt%0d", k), bus.dma_gnt, 1);
      chk($sformatf("bu_a%0d", k), bus.A, k);
      chk($sformatf("bu_rv%0d", k), bus.dma_rvalid, (k > 0) ? 1 : 0);
      if (k > 0) begin
        chk($sformatf("bu_rd%0d", k), bus.dma_rdata, 32'hC0DE_0000 | (k - 1));
      end
    end
    next_cyc();
    bus.dma_req = 1'b0;
    @(negedge clk);
    chk("bu_gnt_end", bus.dma_gnt, 0);
    chk("bu_rv_end", bus.dma_rvalid, 1);
    chk("bu_rd_end", bus.dma_rdata, 32'hC0DE_0003);
    next_cyc();
    @(negedge clk);
    chk("bu_rv_off", bus.dma_rvalid, 0);
    chk("bu_rd_off", bus.dma_rdata, 0);

    // Reset during CPU_RD_WAIT drops the return
    next_cyc();
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 7'h10;
    @(negedge clk);
    chk("rw_stall", bus.cpu_stall, 1);
    next_cyc();
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rw_rdata", bus.cpu_rdata, 0);
    chk("rw_stall0", bus.cpu_stall, 0);
    chk("rw_cen", bus.CEN, 1);

    // Re-issue after release; CPU wins fresh contention
    next_cyc();
    rst_n         = 1'b1;
    bus.dma_req   = 1'b1;
    bus.dma_we    = 1'b1;
    bus.dma_addr  = 7'h30;
    bus.dma_wdata = 32'h0000_0030;
    @(negedge clk);
    chk("ri_cen", bus.CEN, 0);
    chk("ri_oen", bus.OEN, 0);
    chk("ri_a", bus.A, 32'h10);
    chk("ri_stall", bus.cpu_stall, 1);
    chk("ri_dgnt", bus.dma_gnt, 0);

    next_cyc();
    @(negedge clk);
    chk("ri2_stall", bus.cpu_stall, 0);
    chk("ri2_rdata", bus.cpu_rdata, 32'hA5A5_0010);
    chk("ri2_dgnt", bus.dma_gnt, 1);

    next_cyc();
    idle_in();
    next_cyc();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port 128-word data memory between the processor's load/store path and a DMA/debug port. Sits between the core's memory-control outputs and the SRAM pins (CEN/WEN/OEN/A/Data2Mem/ReadDataMem). It hides the memory's one-cycle read latency from the core by raising a stall. Arbitration between the two ports is round-robin.

## Interface
Parameters:
- ADDR_W, 7, memory word-address width
- DATA_W, 32, data width

Ports (clock and reset first):
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- cpu_req  in  1  core requests a memory access this instruction
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  core word address
- cpu_wdata  in  DATA_W  store data
- cpu_rdata  out  DATA_W  load data, valid when cpu_req & !cpu_we & !cpu_stall
- cpu_stall  out  1  core must hold PC and suppress register write
- dma_req  in  1  DMA access request
- dma_we  in  1  1 = write, 0 = read
- dma_addr  in  ADDR_W  DMA word address
- dma_wdata  in  DATA_W  DMA write data
- dma_gnt  out  1  DMA request accepted this cycle (combinational)
- dma_rvalid  out  1  DMA read data valid (cycle after granted read)
- dma_rdata  out  DATA_W  DMA read data
- CEN  out  1  memory chip enable, active-low
- WEN  out  1  memory write enable, active-low
- OEN  out  1  memory output enable, active-low
- A  out  ADDR_W  memory address
- Data2Mem  out  DATA_W  memory write data
- ReadDataMem  in  DATA_W  memory read data, valid the cycle after a read issue

## Operation
- State: `st` ∈ {IDLE, CPU_RD_WAIT}; `rr` priority bit (0 = CPU first); `dma_rd_pend` flag.
- CPU eligible when cpu_req & st==IDLE. In CPU_RD_WAIT the held CPU request is already serviced and must not be re-issued.
- Grant: if exactly one port is eligible, grant it. If both are eligible, grant per `rr`. `rr` toggles to favour the other port after any grant.
- Issue (grant cycle): CEN=0. A and Data2Mem come from the winner. Write: WEN=0, OEN=1. Read: WEN=1, OEN=0.
- No grant: CEN=WEN=OEN=1, A=0, Data2Mem=0.
- CPU read granted: st→CPU_RD_WAIT.
- CPU_RD_WAIT: cpu_rdata=ReadDataMem, cpu_stall=0, st→IDLE.
- cpu_stall = cpu_req & ((st==IDLE & !cpu_gnt) | (st==IDLE & cpu_gnt & !cpu_we)).
  - Stores stall only while losing arbitration.
  - Loads always stall exactly ≥1 cycle.
- DMA read granted: dma_rd_pend←1. The next cycle gives dma_rvalid=1 and dma_rdata=ReadDataMem, then the flag clears unless a new DMA read is granted.
- A DMA issue may overlap the CPU_RD_WAIT cycle (pipelined). The return and the new issue share that cycle.
- cpu_rdata and dma_rdata are 0 when not valid.

## Timing
- Reset values (asynchronous, immediate): st=IDLE, rr=0, dma_rd_pend=0, cpu_stall=0, dma_gnt=0, dma_rvalid=0, CEN=WEN=OEN=1, A=0, Data2Mem=0, rdata outputs 0.
- While rst_n=0, all memory pins are forced idle regardless of requests.
- Load latency: issue cycle N (stall=1), data cycle N+1 (stall=0) when uncontended. Add 1 cycle per lost arbitration.
- Store latency: 0 extra cycles if granted.
- DMA read: dma_gnt in cycle N, dma_rvalid in cycle N+1. Throughput is 1 DMA access/cycle when the CPU is idle.
- Reset asserted in CPU_RD_WAIT: the pending return is dropped. After release, the CPU request (still held) is re-issued as fresh.
- Requests must be held until granted. Dropping a request before grant is legal and has no side effect.

## Structure
- Package `dmem_pkg`:
  - ADDR_W/DATA_W defaults
  - state enum {IDLE, CPU_RD_WAIT}
  - owner enum {OWN_NONE, OWN_CPU, OWN_DMA}
  - pin-level constants MEM_ON=0, MEM_OFF=1
- Sub-module `rr_arb2`: 2-requester round-robin arbiter.
  - Inputs: req[1:0]. Outputs: one-hot gnt[1:0].
  - Owns the `rr` bit, async active-low reset.
- Top level holds the FSM, the pin mux and the return routing.

## Test plan
- Reset: assert rst_n=0 mid-traffic → CEN/WEN/OEN=1, A=0, stall=0, gnt=0 at once. First post-reset contention grants CPU.
- CPU store: addr 7'h05, data 32'hDEADBEEF, no DMA → same cycle CEN=0, WEN=0, A=5, Data2Mem=DEADBEEF, stall=0.
- CPU load: addr 7'h05 → cycle N stall=1, OEN=0. Cycle N+1 stall=0, cpu_rdata=DEADBEEF, no second issue.
- Contention: CPU load 7'h10 and DMA write 7'h20 in the same cycle after reset.
  - Cycle N: CPU wins.
  - Cycle N+1: CPU data returns and DMA is granted the same cycle, A=20.
  - Next contention: DMA wins.
- DMA burst reads of 7'h00..7'h03 with the CPU idle → dma_gnt each cycle, dma_rvalid one cycle later, with data matching memory contents.
- Reset asserted in CPU_RD_WAIT → no rdata delivered. After release with cpu_req still high, the load re-issues: stall=1, then valid data.
